// File: rtl/if_fetch_queue.sv
// Fetch stage: issues PC-driven imem requests, buffers {pc, instr} for decode; 1-cycle ack-to-id latency.
// Backpressure: requests stop when the queue would fill; hold_pc stalls the PC until a fetch is accepted.
module if_fetch_queue #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              hold_pc,
  input  logic              flush,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr_q, addr_next;
  logic              req_q;
  logic [CNT_W-1:0]  count, count_next;
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [ADDR_W-1:0] pc_mem    [DEPTH];
  logic [DATA_W-1:0] instr_mem [DEPTH];
  logic              push, pop, has_space;

  assign push       = (state == REQ) && imem_ack && !flush;
  assign pop        = id_valid && id_ready && !flush;
  assign count_next = count + CNT_W'(push) - CNT_W'(pop);
  assign has_space  = count_next < CNT_W'(DEPTH);

  assign hold_pc   = !push;
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign id_valid  = (count != '0);
  assign id_instr  = instr_mem[rd_ptr];
  assign id_pc     = pc_mem[rd_ptr];

  always_comb begin
    state_next = state;
    addr_next  = addr_q;
    case (state)
      IDLE: begin
        if (!flush && has_space) begin
          state_next = REQ;
          addr_next  = pc_in;
        end
      end
      REQ: begin
        // A redirect with the ack still pending must wait out the stale response.
        if (flush) begin
          state_next = imem_ack ? IDLE : DROP;
        end else if (imem_ack) begin
          if (has_space) begin
            addr_next = addr_q + ADDR_W'(1);
          end else begin
            state_next = IDLE;
          end
        end
      end
      DROP: begin
        if (imem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      addr_q <= '0;
      req_q  <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      state  <= state_next;
      addr_q <= addr_next;
      req_q  <= (state_next != IDLE);
      if (flush) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        count <= count_next;
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  // Entry storage needs no reset: id_valid qualifies the head.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= addr_q;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

  always @(posedge clk) begin
    if (!rst && push) begin
      assert (count != CNT_W'(DEPTH));
    end
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: PC and variable-latency memory models driving a {pc, instr} scoreboard.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        hold_pc;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  if_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .hold_pc(hold_pc), .flush(flush),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t        sb[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] pc_model, redir;
  logic        fl_req, rdy_req, drop;
  int          ack_lat, wcnt, n_push, n_pop;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // One clock cycle: drive at negedge, check the combinational view, advance the environment models.
  task automatic tick();
    ent_t e;
    logic live;
    @(negedge clk);
    flush      = fl_req;
    id_ready   = rdy_req;
    pc_in      = pc_model;
    imem_ack   = imem_req && (wcnt >= ack_lat);
    imem_rdata = mem_word(imem_addr);
    #1;
    vec_cnt++;
    if (id_valid !== logic'(sb.size() != 0)) begin
      err_cnt++;
      $display("FAIL id_valid: got %b want %b (t=%0t)", id_valid, sb.size() != 0, $time);
    end
    if (id_valid && id_ready && !flush) begin
      n_pop++;
      vec_cnt++;
      if (sb.size() == 0) begin
        err_cnt++;
        $display("FAIL pop_empty: got id_pc=%h with no entry expected", id_pc);
      end else begin
        e = sb.pop_front();
        if (id_pc !== e.pc || id_instr !== e.instr) begin
          err_cnt++;
          $display("FAIL id_data: got pc=%h instr=%h want pc=%h instr=%h", id_pc, id_instr, e.pc, e.instr);
        end
      end
    end
    live = imem_ack && !drop && !flush;
    vec_cnt++;
    if (hold_pc !== !live) begin
      err_cnt++;
      $display("FAIL hold_pc: got %b want %b (t=%0t)", hold_pc, !live, $time);
    end
    if (live) begin
      vec_cnt++;
      if (imem_addr !== pc_model) begin
        err_cnt++;
        $display("FAIL imem_addr: got %h want %h", imem_addr, pc_model);
      end
      sb.push_back({pc_model, mem_word(pc_model)});
      n_push++;
    end
    if (imem_ack) drop = 1'b0;
    else if (flush && imem_req) drop = 1'b1;
    wcnt = (imem_req && !imem_ack) ? wcnt + 1 : 0;
    if (flush) begin
      sb.delete();
      pc_model = redir;
    end else if (!hold_pc) begin
      pc_model = pc_model + 32'd1;
    end
  endtask

  task automatic do_reset(input logic [31:0] start);
    rst = 1'b1;
    fl_req = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    pc_model = start; pc_in = start;
    sb.delete();
    drop = 1'b0; wcnt = 0; n_push = 0; n_pop = 0;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    vec_cnt += 4;
    if (imem_req !== 1'b0)   begin err_cnt++; $display("FAIL rst_req: got %b want 0", imem_req); end
    if (imem_addr !== 32'h0) begin err_cnt++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    if (id_valid !== 1'b0)   begin err_cnt++; $display("FAIL rst_valid: got %b want 0", id_valid); end
    if (hold_pc !== 1'b1)    begin err_cnt++; $display("FAIL rst_hold: got %b want 1", hold_pc); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_a;
    ack_lat = 0; rdy_req = 1'b1;
    do_reset(32'h10);
    exp_a = 32'h10;
    for (int i = 0; i < 12; i++) begin
      tick();
      vec_cnt++;
      if (imem_req !== 1'b1 || imem_addr !== exp_a || hold_pc !== 1'b0) begin
        err_cnt++;
        $display("FAIL b2b_seq: got req=%b addr=%h hold=%b want 1 %h 0", imem_req, imem_addr, hold_pc, exp_a);
      end
      exp_a = exp_a + 32'd1;
    end
    vec_cnt++;
    if (n_push != 12 || n_pop != 11) begin
      err_cnt++;
      $display("FAIL b2b_count: got push=%0d pop=%0d want 12 11", n_push, n_pop);
    end
  endtask

  task automatic test_backpressure();
    ack_lat = 0; rdy_req = 1'b0;
    do_reset(32'h100);
    for (int i = 0; i < 10; i++) tick();
    vec_cnt++;
    if (n_push != 4 || imem_req !== 1'b0 || hold_pc !== 1'b1 || id_pc !== 32'h100) begin
      err_cnt++;
      $display("FAIL full_stall: got push=%0d req=%b hold=%b head=%h want 4 0 1 00000100",
               n_push, imem_req, hold_pc, id_pc);
    end
    rdy_req = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    vec_cnt++;
    if (n_push != 23 || n_pop != 20 || pc_model !== 32'h100 + 32'd23) begin
      err_cnt++;
      $display("FAIL resume: got push=%0d pop=%0d pc=%h want 23 20 %h", n_push, n_pop, pc_model, 32'h117);
    end
  endtask

  task automatic test_slow_mem();
    logic [31:0] start, prev_addr;
    logic        prev_wait;
    ack_lat = 3; rdy_req = 1'b1;
    do_reset(32'h200);
    start = pc_model; prev_wait = 1'b0; prev_addr = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (prev_wait) begin
        vec_cnt++;
        if (imem_addr !== prev_addr) begin
          err_cnt++;
          $display("FAIL addr_stable: got %h want %h", imem_addr, prev_addr);
        end
      end
      prev_wait = imem_req && !imem_ack;
      prev_addr = imem_addr;
    end
    vec_cnt++;
    if (n_push != 10 || pc_model - start != 32'(n_push)) begin
      err_cnt++;
      $display("FAIL slow_rate: got acks=%0d pc_adv=%0d want 10 10", n_push, pc_model - start);
    end
  endtask

  task automatic test_flush_drop();
    ack_lat = 1000; rdy_req = 1'b1;
    do_reset(32'h20);
    tick();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      err_cnt++; $display("FAIL drop_pre: got req=%b addr=%h want 1 00000020", imem_req, imem_addr);
    end
    fl_req = 1'b1; redir = 32'h80;
    tick();
    fl_req = 1'b0;
    tick();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h20 || id_valid !== 1'b0) begin
      err_cnt++; $display("FAIL drop_hold: got req=%b addr=%h valid=%b want 1 00000020 0", imem_req, imem_addr, id_valid);
    end
    ack_lat = 0;
    tick();
    tick();
    vec_cnt++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      err_cnt++; $display("FAIL drop_idle: got req=%b valid=%b want 0 0", imem_req, id_valid);
    end
    tick();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      err_cnt++; $display("FAIL drop_redir: got req=%b addr=%h want 1 00000080", imem_req, imem_addr);
    end
    tick();
    vec_cnt++;
    if (id_valid !== 1'b1 || id_pc !== 32'h80) begin
      err_cnt++; $display("FAIL drop_first: got valid=%b pc=%h want 1 00000080", id_valid, id_pc);
    end
  endtask

  task automatic test_flush_ack();
    ack_lat = 0; rdy_req = 1'b0;
    do_reset(32'h40);
    tick();
    tick();
    fl_req = 1'b1; redir = 32'h90;
    tick();
    vec_cnt++;
    if (imem_ack !== 1'b1 || hold_pc !== 1'b1) begin
      err_cnt++; $display("FAIL fa_hold: got ack=%b hold=%b want 1 1", imem_ack, hold_pc);
    end
    fl_req = 1'b0;
    tick();
    vec_cnt++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
      err_cnt++; $display("FAIL fa_clear: got req=%b valid=%b want 0 0", imem_req, id_valid);
    end
    tick();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h90) begin
      err_cnt++; $display("FAIL fa_restart: got req=%b addr=%h want 1 00000090", imem_req, imem_addr);
    end
    rdy_req = 1'b1;
    for (int i = 0; i < 5; i++) tick();
  endtask

  task automatic test_async_reset();
    ack_lat = 0; rdy_req = 1'b1;
    do_reset(32'h300);
    for (int i = 0; i < 10; i++) begin
      rdy_req = logic'($urandom_range(0, 1));
      tick();
    end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (imem_req !== 1'b0 || id_valid !== 1'b0 || hold_pc !== 1'b1 || imem_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL async_rst: got req=%b valid=%b hold=%b addr=%h want 0 0 1 0", imem_req, id_valid, hold_pc, imem_addr);
    end
    @(posedge clk);
    @(negedge clk);
    pc_model = 32'h0; pc_in = 32'h0;
    sb.delete();
    drop = 1'b0; wcnt = 0; fl_req = 1'b0; flush = 1'b0; imem_ack = 1'b0;
    rst = 1'b0;
    rdy_req = 1'b1;
    tick();
    vec_cnt++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      err_cnt++; $display("FAIL rst_restart: got req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    for (int i = 0; i < 8; i++) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fl_req = 1'b0; redir = '0;
    pc_in = '0; pc_model = '0; imem_ack = 1'b0; imem_rdata = '0;
    id_ready = 1'b0; rdy_req = 1'b0; drop = 1'b0;
    ack_lat = 0; wcnt = 0; n_push = 0; n_pop = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_slow_mem();
    test_flush_drop();
    test_flush_ack();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
